// File: rtl/reduce_scheduler_pkg.sv
// reduce_scheduler_pkg
//   Shared defaults and helpers for the reduction scheduler slice.
//   - REDUCE_REQS / REDUCE_TAG_DEPTH : default requester count and tag FIFO depth
//   - MAX_EMBEDDING_DIM              : default operands per vector
//   - PRODUCT_I / PRODUCT_F          : integer/fraction bits of one Q.K product
//   - q_width()                      : fixed-point width from integer/fraction bits
//   - rr_wrap()                      : (base + off) mod n, used by the round-robin scan
package reduce_scheduler_pkg;

   localparam int unsigned REDUCE_REQS       = 4;
   localparam int unsigned REDUCE_TAG_DEPTH  = 8;
   localparam int unsigned MAX_EMBEDDING_DIM = 64;
   localparam int unsigned PRODUCT_I         = 4;
   localparam int unsigned PRODUCT_F         = 4;

   function automatic int unsigned q_width(input int unsigned i_bits, input int unsigned f_bits);
      return i_bits + f_bits;
   endfunction

   function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/reduce_tag_fifo.sv
// reduce_tag_fifo
//   In-order FIFO holding the requester tag of every item in flight in the tree.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     push, din    write a tag (ignored when full)
//     pop, dout    drop the head tag (ignored when empty); dout shows the head
//     count        number of stored tags
//     full, empty  derived from count
module reduce_tag_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign count   = count_q;
   assign dout    = mem_q[head_q];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_ok) tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
      if (pop_ok)  head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
      if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
      if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: count gates every read that matters.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[tail_q] <= din;
   end

endmodule

// File: rtl/reduce_scheduler.sv
// reduce_scheduler
//   Shares one tree_reduce pipeline between N_REQ requesters. A round-robin
//   arbiter issues one vector per cycle straight into the tree (no data-path
//   registers); a tag FIFO remembers the owner of each in-flight item so the
//   returning sums are steered back in issue order.
//   Ports:
//     clk, rst                           clock, asynchronous active-low reset
//     req_vld/req_rdy/req_list/req_mask  requester side, one vector per handshake
//     tree_vld/tree_rdy/tree_list        issue to the shared tree
//     tree_sum_vld/tree_sum_rdy/tree_sum result from the tree
//     resp_vld/resp_rdy/resp_sum         per-requester result, shared sum bus
//     inflight, busy                     issued-not-returned count, count != 0
//     proto_err                          sticky: result arrived with nothing outstanding
module reduce_scheduler
   import reduce_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ     = REDUCE_REQS,
   parameter int unsigned LEN       = MAX_EMBEDDING_DIM,
   parameter int unsigned W_IN      = q_width(PRODUCT_I, PRODUCT_F),
   parameter int unsigned W_OUT     = W_IN + $clog2(LEN),
   parameter int unsigned TAG_DEPTH = REDUCE_TAG_DEPTH,
   parameter int unsigned TAG_W     = $clog2(N_REQ),
   localparam int unsigned CNT_W    = $clog2(TAG_DEPTH + 1)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [N_REQ-1:0]                      req_vld,
   output logic [N_REQ-1:0]                      req_rdy,
   input  logic [N_REQ-1:0][LEN-1:0][W_IN-1:0]   req_list,
   input  logic [N_REQ-1:0]                      req_mask,
   output logic                                  tree_vld,
   input  logic                                  tree_rdy,
   output logic [LEN-1:0][W_IN-1:0]              tree_list,
   input  logic                                  tree_sum_vld,
   output logic                                  tree_sum_rdy,
   input  logic signed [W_OUT-1:0]               tree_sum,
   output logic [N_REQ-1:0]                      resp_vld,
   input  logic [N_REQ-1:0]                      resp_rdy,
   output logic signed [W_OUT-1:0]               resp_sum,
   output logic [CNT_W-1:0]                      inflight,
   output logic                                  busy,
   output logic                                  proto_err
);

   typedef logic [TAG_W-1:0] reduce_tag_t;

   reduce_tag_t      rr_ptr_q, rr_ptr_d, grant, cand, head;
   logic [N_REQ-1:0] eligible;
   logic             any_elig, issue, pop, stray;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             proto_err_q;

   assign eligible = req_vld & req_mask;

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      grant    = '0;
      cand     = '0;
      any_elig = 1'b0;
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         cand = TAG_W'(rr_wrap(32'(rr_ptr_q), unsigned'(k), N_REQ));
         if (eligible[cand]) begin
            grant    = cand;
            any_elig = 1'b1;
         end
      end
   end

   // Full is judged on the registered count only, so a same-cycle pop never
   // frees a slot for issue (keeps resp_rdy off the tree_vld path).
   assign issue     = rst & any_elig & tree_rdy & ~fifo_full;
   assign tree_vld  = issue;
   assign tree_list = issue ? req_list[grant] : '0;

   always_comb begin
      req_rdy = '0;
      if (issue) req_rdy[grant] = 1'b1;
   end

   assign rr_ptr_d = issue ? TAG_W'(rr_wrap(32'(grant), 32'd1, N_REQ)) : rr_ptr_q;

   reduce_tag_fifo #(
      .DEPTH(TAG_DEPTH),
      .W    (TAG_W)
   ) u_tag_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (issue),
      .pop  (pop),
      .din  (grant),
      .dout (head),
      .count(fifo_count),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   // Return steering. With no tag outstanding the tree is drained so a stray
   // result cannot wedge it, and the event is flagged.
   always_comb begin
      resp_vld     = '0;
      tree_sum_rdy = 1'b0;
      pop          = 1'b0;
      stray        = 1'b0;
      if (rst) begin
         if (!fifo_empty) begin
            resp_vld[head] = tree_sum_vld;
            tree_sum_rdy   = resp_rdy[head];
            pop            = tree_sum_vld & resp_rdy[head];
         end else begin
            tree_sum_rdy = 1'b1;
            stray        = tree_sum_vld;
         end
      end
   end

   assign resp_sum  = tree_sum;
   assign inflight  = fifo_count;
   assign busy      = (fifo_count != '0);
   assign proto_err = proto_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (stray) proto_err_q <= 1'b1;
      end
   end

endmodule
